fetch_sequencer: RTL
====================

# fetch_sequencer

Fetch-stage controller that owns and sequences the program counter. It arbitrates between the sequential next-PC, branch/jump redirects from execute and trap redirects. It drives a wait-stated instruction-memory request handshake and holds a one-deep fetched-instruction buffer toward decode, honouring hazard stalls. It also implements a HALTED state (ebreak/wfi) with resume and trap wake-up.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets immediately; released synchronously by the system).
- PCTarget  in  32  branch/jump target from execute.
- PCSrc  in  1  one-cycle redirect request; PC=PCTarget when 1.
- trap  in  1  one-cycle trap request; highest priority.
- halt  in  1  one-cycle pulse from decode on ebreak/wfi; valid only with instr_valid && !stall.
- resume  in  1  one-cycle pulse leaving HALTED.
- stall  in  1  decode cannot accept; holds buffer.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= program_counter).
- imem_ready  in  1  memory returns imem_rdata this cycle for imem_addr.
- imem_rdata  in  32  instruction word.
- instr  out  32  buffered instruction to decode.
- instr_pc  out  32  address of instr.
- instr_valid  out  1  buffer full.
- flush  out  1  combinational; kill younger in-flight instructions.
- program_counter  out  32  next address to fetch.
- fetch_count  out  32  accepted fetches, wraps at 2^32.

## Operation
- States: IDLE, FETCH, HALTED. Reset → IDLE; IDLE → FETCH unconditionally next cycle.
- imem_req = (state==FETCH) && !(instr_valid && stall). The memory is stateless per cycle, so a request may drop without ready.
- Fetch accept = imem_req && imem_ready && no redirect this cycle. On accept: instr←imem_rdata, instr_pc←program_counter, instr_valid←1, program_counter←program_counter+4 (mod 2^32), fetch_count+1.
- Buffer consumed when instr_valid && !stall. If consumed with no accept, instr_valid←0. Simultaneous consume and accept keeps instr_valid=1 with the new word.
- Per-cycle priority: trap > PCSrc > halt > sequential.
  - trap (any state except IDLE): program_counter←TRAP_VECTOR, instr_valid←0, state←FETCH, flush=1.
  - PCSrc (FETCH only; ignored in HALTED/IDLE): program_counter←PCTarget, instr_valid←0, flush=1.
  - In both redirect cases, fetched data in that cycle is discarded and not counted.
- halt (FETCH, buffer consumed): state←HALTED, instr_valid←0, no request issued; program_counter keeps its value.
- HALTED: imem_req=0. resume → FETCH at the held program_counter. trap → FETCH at TRAP_VECTOR.
- Redirect wins over stall: the buffer is cleared even while stall=1.
- PCTarget bits [1:0] are passed unchanged; alignment checking belongs to execute.

## Timing
- Reset values: program_counter=RESET_VECTOR, instr=0, instr_pc=0, instr_valid=0, fetch_count=0, state=IDLE; therefore imem_req=0 and flush=0.
- First imem_req comes one cycle after reset release, at address RESET_VECTOR.
- Latency: imem_ready in cycle N gives instr_valid=1 in cycle N+1, when the next request is already issued. With zero wait states the block sustains one instruction per cycle.
- Redirect in cycle N: flush=1 in N, imem_addr=target in N+1, earliest instr_valid in N+2.
- Asserting reset mid-fetch clears everything asynchronously; any outstanding request is abandoned.

## Structure
- Shared package holds: fetch_state_t enum {IDLE, FETCH, HALTED}, and constants RESET_VECTOR_DEFAULT, TRAP_VECTOR_DEFAULT, INSTR_BYTES=4.
- One natural sub-module: fetch_buffer (one-deep instruction/pc/valid register with load, consume and clear). Next-PC mux and FSM stay in the top.

## Test plan
- Reset release, imem_ready always 1 → addresses 0x0,0x4,0x8 on consecutive cycles; instr_valid from cycle 2; fetch_count=3 after 3 accepts.
- imem_ready low 2 cycles at 0x8 → imem_addr held 0x8, instr_valid drops once consumed, then resumes with 0x8.
- stall=1 for 3 cycles with buffer full → imem_req=0, instr/instr_pc stable. On release, the next fetch is 0xC.
- PCSrc=1, PCTarget=0x40 in the same cycle as imem_ready at 0x10 → flush=1, data dropped, count unchanged, next imem_addr=0x40.
- trap and PCSrc simultaneously (PCTarget=0x80) → next imem_addr=0x100; also trap while stall=1 → buffer cleared.
- halt on instr at 0x20 → HALTED, imem_req=0 for 5 cycles. resume → fetch at 0x24. Repeat with trap instead of resume → fetch at 0x100. Assert reset mid-HALTED → all outputs at reset values.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_pkg
// Purpose  : Shared state type and address constants for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;
  localparam logic [31:0] INSTR_BYTES          = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_if
// Purpose  : Redirect, control, instruction-memory and decode-side signals.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if;

  logic [31:0] PCTarget;
  logic        PCSrc;
  logic        trap;
  logic        halt;
  logic        resume;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        flush;
  logic [31:0] program_counter;
  logic [31:0] fetch_count;

  // master is the fetch sequencer itself
  modport master (
    input  PCTarget, PCSrc, trap, halt, resume, stall, imem_ready, imem_rdata,
    output imem_req, imem_addr, instr, instr_pc, instr_valid, flush,
           program_counter, fetch_count
  );

  modport slave (
    output PCTarget, PCSrc, trap, halt, resume, stall, imem_ready, imem_rdata,
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, flush,
           program_counter, fetch_count
  );

endinterface
`default_nettype wire

// File: rtl/fetch_sequencer_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_buffer
// Purpose  : One-deep fetched-instruction register with load/consume/clear.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer_buffer
  import fetch_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic        consume,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  // clear beats load so a redirect discards same-cycle return data
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = load_instr;
      pc_d    = load_pc;
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = pc_q;
  assign instr_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Fetch-stage PC owner: redirect arbitration, imem handshake, halt.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;

  logic consume;
  logic trap_take;
  logic branch_take;
  logic halt_take;
  logic redirect;
  logic accept;

  assign consume     = bus.instr_valid && !bus.stall;
  assign trap_take   = bus.trap && (state_q != IDLE);
  assign branch_take = bus.PCSrc && (state_q == FETCH);
  assign redirect    = trap_take || branch_take;
  assign halt_take   = bus.halt && (state_q == FETCH) && consume && !redirect;

  assign bus.imem_req  = (state_q == FETCH) && !(bus.instr_valid && bus.stall);
  // a halting cycle must not advance the PC, so its return data is dropped
  assign accept        = bus.imem_req && bus.imem_ready && !redirect && !halt_take;
  assign bus.imem_addr = pc_q;
  assign bus.flush     = redirect;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;

    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (trap_take) state_d = FETCH;
               else if (halt_take) state_d = HALTED;
      HALTED:  if (trap_take || bus.resume) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    if (trap_take)        pc_d = TRAP_VECTOR;
    else if (branch_take) pc_d = bus.PCTarget;
    else if (accept)      pc_d = pc_q + INSTR_BYTES;

    if (accept) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  fetch_sequencer_buffer u_fetch_buffer (
    .clk         (clk),
    .reset       (reset),
    .clear       (redirect || halt_take),
    .load        (accept),
    .consume     (consume),
    .load_instr  (bus.imem_rdata),
    .load_pc     (pc_q),
    .instr       (bus.instr),
    .instr_pc    (bus.instr_pc),
    .instr_valid (bus.instr_valid)
  );

  assign bus.program_counter = pc_q;
  assign bus.fetch_count     = count_q;

endmodule
`default_nettype wire
